// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: state encoding and a constant-width helper.
package serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

  // Ceiling log2, never below 1 so a single-step counter still has a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, busy
  );

endinterface

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice built from full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co       = c[DIGIT];
  // Carry into the slice's top bit; on the last step this is the carry into the word MSB.
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract: DIGIT bits per clock, LSB-first, one registered carry.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1
) (
  input logic            clk,
  input logic            rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CntW  = clog2(STEPS);
  localparam logic [CntW-1:0] LastStep = CntW'(STEPS - 1);

  if (DIGIT == 0 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT-1:0]  slice_s;
  logic              slice_co;
  logic              slice_c_msb;
  logic [WIDTH-1:0]  slice_ext;
  logic [WIDTH-1:0]  res_shift;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x        (a_q[DIGIT-1:0]),
    .y        (b_q[DIGIT-1:0]),
    .ci       (carry_q),
    .s        (slice_s),
    .co       (slice_co),
    .c_msb_in (slice_c_msb)
  );

  // New digits enter from the MSB side so the word is aligned after STEPS shifts.
  always_comb begin
    slice_ext              = '0;
    slice_ext[DIGIT-1:0]   = slice_s;
    res_shift              = (res_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_shift;
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          state_d = StDone;
          sum_d   = res_shift;
          cout_d  = slice_co;
          ovf_d   = slice_co ^ slice_c_msb;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StRun);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed vector bench for serial_adder: 16/1 table, handshake sequences, exhaustive 4-bit configs.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(16)) bus16 ();
  serial_adder_if #(.WIDTH(4))  bus42 ();
  serial_adder_if #(.WIDTH(4))  bus44 ();

  serial_adder #(.WIDTH(16), .DIGIT(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  serial_adder #(.WIDTH(4),  .DIGIT(2)) dut42 (.clk(clk), .rst_n(rst_n), .bus(bus42.slave));
  serial_adder #(.WIDTH(4),  .DIGIT(4)) dut44 (.clk(clk), .rst_n(rst_n), .bus(bus44.slave));

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one op on the 16-bit DUT and count edges until out_valid; prev is the held result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [15:0] prev, output int lat);
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = cin;
    bus16.sub      = sub;
    bus16.in_valid = 1'b1;
    check("accept_in_ready", 32'(bus16.in_ready), 32'd1);
    tick();
    bus16.in_valid = 1'b0;
    check("run_busy", {30'd0, bus16.busy, bus16.in_ready}, 32'b10);
    lat = 0;
    while (!bus16.out_valid && lat < 40) begin
      if (lat == 8) check("hold_in_run", 32'(bus16.sum), 32'(prev));
      tick();
      lat++;
    end
  endtask

  task automatic release16();
    bus16.out_ready = 1'b1;
    tick();
    bus16.out_ready = 1'b0;
    check("back_to_idle", {30'd0, bus16.in_ready, bus16.out_valid}, 32'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [15:0] prev;
    logic        saw_valid;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};

    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.out_ready = 1'b0;
    bus42.in_valid = 1'b0; bus42.a = '0; bus42.b = '0; bus42.cin = 1'b0; bus42.sub = 1'b0;
    bus42.out_ready = 1'b1;
    bus44.in_valid = 1'b0; bus44.a = '0; bus44.b = '0; bus44.cin = 1'b0; bus44.sub = 1'b0;
    bus44.out_ready = 1'b1;

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_flags", {27'd0, bus16.in_ready, bus16.out_valid, bus16.busy, bus16.cout,
                          bus16.overflow}, 32'b10000);
    check("reset_sum", 32'(bus16.sum), 32'd0);
    rst_n = 1'b1;
    tick();

    prev = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, prev, lat);
      check($sformatf("latency_v%0d", i), 32'(lat), 32'd16);
      check($sformatf("result_v%0d", i), {14'd0, bus16.sum, bus16.cout, bus16.overflow},
            {14'd0, vecs[i].sum, vecs[i].cout, vecs[i].ovf});
      release16();
      prev = vecs[i].sum;
    end

    // Backpressure in DONE with in_valid pulses that must be ignored.
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, prev, lat);
    bus16.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus16.in_valid = i[0];
      bus16.a        = 16'hDEAD;
      tick();
      check("bp_flags", {29'd0, bus16.out_valid, bus16.in_ready, bus16.busy}, 32'b100);
      check("bp_result", {14'd0, bus16.sum, bus16.cout, bus16.overflow}, {14'd0, 16'h0100, 2'b00});
    end
    // Output taken with in_valid high: the same edge must not accept a new op.
    bus16.in_valid  = 1'b1;
    bus16.out_ready = 1'b1;
    tick();
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    check("no_same_cycle_accept", {29'd0, bus16.in_ready, bus16.busy, bus16.out_valid}, 32'b100);
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h0100, lat);
    check("second_op_latency", 32'(lat), 32'd16);
    check("second_op_result", {14'd0, bus16.sum, bus16.cout, bus16.overflow},
          {14'd0, 16'h5555, 2'b00});
    release16();

    // Reset during RUN discards the op and clears the held result.
    bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.in_valid = 1'b1;
    tick();
    bus16.in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    check("midrun_reset_flags", {27'd0, bus16.in_ready, bus16.out_valid, bus16.busy,
                                 bus16.cout, bus16.overflow}, 32'b10000);
    check("midrun_reset_sum", 32'(bus16.sum), 32'd0);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (30) begin
      tick();
      saw_valid = saw_valid | bus16.out_valid;
    end
    check("aborted_no_result", 32'(saw_valid), 32'd0);

    // Exhaustive 4-bit: DIGIT=2 (2 steps) and DIGIT=4 (1 step), accepted on the same edge.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          for (int is = 0; is < 2; is++) begin
            logic [3:0] av, bv, beff;
            logic       cv, sv, c0, ovf;
            logic [4:0] full;
            logic [6:0] exp;
            av   = 4'(ia);
            bv   = 4'(ib);
            cv   = ic[0];
            sv   = is[0];
            beff = sv ? ~bv : bv;
            c0   = sv ? 1'b1 : cv;
            full = {1'b0, av} + {1'b0, beff} + {4'd0, c0};
            ovf  = (av[3] == beff[3]) && (full[3] != av[3]);
            exp  = {1'b1, full[3:0], full[4], ovf};

            bus42.a = av; bus42.b = bv; bus42.cin = cv; bus42.sub = sv; bus42.in_valid = 1'b1;
            bus44.a = av; bus44.b = bv; bus44.cin = cv; bus44.sub = sv; bus44.in_valid = 1'b1;
            check("small_ready", {30'd0, bus42.in_ready, bus44.in_ready}, 32'b11);
            tick();
            bus42.in_valid = 1'b0;
            bus44.in_valid = 1'b0;
            tick();
            check($sformatf("w4d4 a=%h b=%h c=%b s=%b", av, bv, cv, sv),
                  {25'd0, bus44.out_valid, bus44.sum, bus44.cout, bus44.overflow}, {25'd0, exp});
            check("w4d2_not_yet_valid", 32'(bus42.out_valid), 32'd0);
            tick();
            check($sformatf("w4d2 a=%h b=%h c=%b s=%b", av, bv, cv, sv),
                  {25'd0, bus42.out_valid, bus42.sum, bus42.cout, bus42.overflow}, {25'd0, exp});
            tick();
          end
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
